// File: rtl/idu_pipe_if.sv
// idu_pipe_if: fetch-to-execute bus for the decode stage.
//   master : IFU/EXU side. It drives in_valid/in_inst/in_pc and out_ready.
//   slave  : decode stage. It drives in_ready, out_valid and the decoded bundle.
//   Params : XLEN (immediate width), PC_W (pc width).
interface idu_pipe_if #(
  parameter int XLEN = 64,
  parameter int PC_W = 64
);
  logic            in_valid;
  logic            in_ready;
  logic [31:0]     in_inst;
  logic [PC_W-1:0] in_pc;
  logic            out_valid;
  logic            out_ready;
  logic [PC_W-1:0] out_pc;
  logic [4:0]      rs1;
  logic [4:0]      rs2;
  logic [4:0]      rd;
  logic [XLEN-1:0] imm;
  logic [2:0]      fmt;
  logic [2:0]      funct3;
  logic            funct7b5;
  logic            reg_wr;
  logic            mem_rd;
  logic            mem_wr;
  logic            branch;
  logic            jump;
  logic            word_op;
  logic            illegal;
  logic            ebreak;
  logic            ecall;

  modport master (
    output in_valid, in_inst, in_pc, out_ready,
    input  in_ready, out_valid, out_pc, rs1, rs2, rd, imm, fmt, funct3,
           funct7b5, reg_wr, mem_rd, mem_wr, branch, jump, word_op,
           illegal, ebreak, ecall
  );

  modport slave (
    input  in_valid, in_inst, in_pc, out_ready,
    output in_ready, out_valid, out_pc, rs1, rs2, rd, imm, fmt, funct3,
           funct7b5, reg_wr, mem_rd, mem_wr, branch, jump, word_op,
           illegal, ebreak, ecall
  );
endinterface

// File: rtl/idu_pipe.sv
// idu_pipe: registered RV32I/RV64I decode stage that sits between the IFU and the EXU.
//   clk, rst_n : rising-edge clock and asynchronous active-low reset.
//   flush      : kills the held bundle and drops any input offered in the same cycle.
//   bus        : idu_pipe_if.slave. It carries the valid/ready input (inst, pc) and the
//                valid/ready output bundle (register indices, immediate, format, flags).
// The stage holds one bundle. Latency is one cycle and throughput is one instruction
// per cycle while out_ready stays high.
module idu_pipe #(
  parameter int XLEN = 64,
  parameter int PC_W = 64
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       flush,
  idu_pipe_if.slave  bus
);

  localparam bit RV64 = (XLEN == 64);

  localparam logic [2:0] FMT_R = 3'd0;
  localparam logic [2:0] FMT_I = 3'd1;
  localparam logic [2:0] FMT_S = 3'd2;
  localparam logic [2:0] FMT_B = 3'd3;
  localparam logic [2:0] FMT_U = 3'd4;
  localparam logic [2:0] FMT_J = 3'd5;

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OPIMM32= 7'b0011011;
  localparam logic [6:0] OPC_OP32   = 7'b0111011;
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;
  localparam logic [6:0] OPC_FENCE  = 7'b0001111;

  typedef struct packed {
    logic [PC_W-1:0] pc;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [4:0]      rd;
    logic [XLEN-1:0] imm;
    logic [2:0]      fmt;
    logic [2:0]      funct3;
    logic            funct7b5;
    logic            reg_wr;
    logic            mem_rd;
    logic            mem_wr;
    logic            branch;
    logic            jump;
    logic            word_op;
    logic            illegal;
    logic            ebreak;
    logic            ecall;
  } dec_t;

  dec_t        dec_d, dec_q;
  logic        vld_q;
  logic        accept;
  logic [31:0] inst;
  logic [6:0]  opc;
  logic [2:0]  f3;
  logic [6:0]  f7;
  logic [31:0] imm32;
  logic [63:0] imm64;

  assign inst = bus.in_inst;
  assign opc  = inst[6:0];
  assign f3   = inst[14:12];
  assign f7   = inst[31:25];

  assign bus.in_ready = !vld_q || bus.out_ready;
  assign accept       = bus.in_valid && bus.in_ready && !flush;

  always_comb begin
    dec_d          = '0;
    dec_d.pc       = bus.in_pc;
    dec_d.rs1      = inst[19:15];
    dec_d.rs2      = inst[24:20];
    dec_d.rd       = inst[11:7];
    dec_d.funct3   = f3;
    dec_d.funct7b5 = inst[30];
    dec_d.fmt      = FMT_R;

    // The opcode includes inst[1:0], so a compressed encoding (inst[1:0] != 2'b11)
    // never matches a case item and falls through to the default illegal arm.
    unique case (opc)
      OPC_LUI, OPC_AUIPC: begin
        dec_d.fmt    = FMT_U;
        dec_d.reg_wr = 1'b1;
      end
      OPC_JAL: begin
        dec_d.fmt    = FMT_J;
        dec_d.jump   = 1'b1;
        dec_d.reg_wr = 1'b1;
      end
      OPC_JALR: begin
        dec_d.fmt     = FMT_I;
        dec_d.jump    = 1'b1;
        dec_d.reg_wr  = 1'b1;
        dec_d.illegal = (f3 != 3'b000);
      end
      OPC_BRANCH: begin
        dec_d.fmt     = FMT_B;
        dec_d.branch  = 1'b1;
        dec_d.illegal = (f3 == 3'b010) || (f3 == 3'b011);
      end
      OPC_LOAD: begin
        dec_d.fmt     = FMT_I;
        dec_d.mem_rd  = 1'b1;
        dec_d.reg_wr  = 1'b1;
        // ld (011) and lwu (110) exist only on RV64.
        dec_d.illegal = (f3 == 3'b111) ||
                        (!RV64 && ((f3 == 3'b011) || (f3 == 3'b110)));
      end
      OPC_STORE: begin
        dec_d.fmt     = FMT_S;
        dec_d.mem_wr  = 1'b1;
        dec_d.illegal = (f3 > 3'b011) || (!RV64 && (f3 == 3'b011));
      end
      OPC_OPIMM: begin
        dec_d.fmt    = FMT_I;
        dec_d.reg_wr = 1'b1;
        // Shift-immediates use a 6-bit shamt on RV64. On RV32, bit 25 must be clear.
        if (f3 == 3'b001)
          dec_d.illegal = (inst[31:26] != 6'b000000) || (!RV64 && inst[25]);
        else if (f3 == 3'b101)
          dec_d.illegal = ((inst[31:26] != 6'b000000) && (inst[31:26] != 6'b010000)) ||
                          (!RV64 && inst[25]);
      end
      OPC_OP: begin
        dec_d.fmt     = FMT_R;
        dec_d.reg_wr  = 1'b1;
        dec_d.illegal = !((f7 == 7'b0000000) ||
                          ((f7 == 7'b0100000) && ((f3 == 3'b000) || (f3 == 3'b101))));
      end
      OPC_OPIMM32: begin
        dec_d.fmt     = FMT_I;
        dec_d.word_op = 1'b1;
        dec_d.reg_wr  = 1'b1;
        // addiw / slliw / srliw / sraiw. W shifts take a 5-bit shamt only.
        unique case (f3)
          3'b000:  dec_d.illegal = 1'b0;
          3'b001:  dec_d.illegal = (f7 != 7'b0000000);
          3'b101:  dec_d.illegal = (f7 != 7'b0000000) && (f7 != 7'b0100000);
          default: dec_d.illegal = 1'b1;
        endcase
        if (!RV64) dec_d.illegal = 1'b1;
      end
      OPC_OP32: begin
        dec_d.fmt     = FMT_R;
        dec_d.word_op = 1'b1;
        dec_d.reg_wr  = 1'b1;
        dec_d.illegal = !(((f7 == 7'b0000000) &&
                           ((f3 == 3'b000) || (f3 == 3'b001) || (f3 == 3'b101))) ||
                          ((f7 == 7'b0100000) && ((f3 == 3'b000) || (f3 == 3'b101))));
        if (!RV64) dec_d.illegal = 1'b1;
      end
      OPC_SYSTEM: begin
        dec_d.fmt = FMT_I;
        if (inst == 32'h0000_0073)      dec_d.ecall   = 1'b1;
        else if (inst == 32'h0010_0073) dec_d.ebreak  = 1'b1;
        else                            dec_d.illegal = 1'b1;
      end
      OPC_FENCE: begin
        dec_d.fmt = FMT_I;
      end
      default: dec_d.illegal = 1'b1;
    endcase

    // An illegal instruction must not trigger any side effect downstream.
    if (dec_d.illegal) begin
      dec_d.reg_wr  = 1'b0;
      dec_d.mem_rd  = 1'b0;
      dec_d.mem_wr  = 1'b0;
      dec_d.branch  = 1'b0;
      dec_d.jump    = 1'b0;
      dec_d.word_op = 1'b0;
      dec_d.ebreak  = 1'b0;
      dec_d.ecall   = 1'b0;
    end
    if (dec_d.rd == 5'd0) dec_d.reg_wr = 1'b0;
  end

  // Every immediate fits in 32 bits. Build it at that width, then sign-extend it to XLEN.
  always_comb begin
    unique case (dec_d.fmt)
      FMT_I:   imm32 = {{20{inst[31]}}, inst[31:20]};
      FMT_S:   imm32 = {{20{inst[31]}}, inst[31:25], inst[11:7]};
      FMT_B:   imm32 = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
      FMT_U:   imm32 = {inst[31:12], 12'b0};
      FMT_J:   imm32 = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
      default: imm32 = 32'b0;
    endcase
  end

  assign imm64 = {{32{imm32[31]}}, imm32};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_q <= 1'b0;
      dec_q <= '0;
    end else if (flush) begin
      vld_q <= 1'b0;
    end else if (accept) begin
      vld_q     <= 1'b1;
      dec_q     <= dec_d;
      dec_q.imm <= imm64[XLEN-1:0];
    end else if (bus.out_ready) begin
      vld_q <= 1'b0;
    end
  end

  assign bus.out_valid = vld_q;
  assign bus.out_pc    = dec_q.pc;
  assign bus.rs1       = dec_q.rs1;
  assign bus.rs2       = dec_q.rs2;
  assign bus.rd        = dec_q.rd;
  assign bus.imm       = dec_q.imm;
  assign bus.fmt       = dec_q.fmt;
  assign bus.funct3    = dec_q.funct3;
  assign bus.funct7b5  = dec_q.funct7b5;
  assign bus.reg_wr    = dec_q.reg_wr;
  assign bus.mem_rd    = dec_q.mem_rd;
  assign bus.mem_wr    = dec_q.mem_wr;
  assign bus.branch    = dec_q.branch;
  assign bus.jump      = dec_q.jump;
  assign bus.word_op   = dec_q.word_op;
  assign bus.illegal   = dec_q.illegal;
  assign bus.ebreak    = dec_q.ebreak;
  assign bus.ecall     = dec_q.ecall;

endmodule

// File: tb/tb_idu_pipe.sv
// tb_idu_pipe: scoreboard bench for idu_pipe at XLEN=64 and XLEN=32.
module tb_idu_pipe;
  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  logic flush = 1'b0;
  always #5 clk = ~clk;

  idu_pipe_if #(.XLEN(64), .PC_W(64)) b64();
  idu_pipe_if #(.XLEN(32), .PC_W(32)) b32();

  idu_pipe #(.XLEN(64), .PC_W(64)) dut64 (.clk(clk), .rst_n(rst_n), .flush(flush), .bus(b64));
  idu_pipe #(.XLEN(32), .PC_W(32)) dut32 (.clk(clk), .rst_n(rst_n), .flush(flush), .bus(b32));

  // Flag vector order: {reg_wr, mem_rd, mem_wr, branch, jump, word_op, illegal, ebreak, ecall}
  localparam logic [8:0] RW = 9'h100, MR = 9'h080, MW = 9'h040, BR = 9'h020, JP = 9'h010,
                         WO = 9'h008, IL = 9'h004, EB = 9'h002, EC = 9'h001, NF = 9'h000;

  typedef struct packed {
    logic [63:0] pc;
    logic [2:0]  fmt;
    logic [4:0]  rd, rs1, rs2;
    logic [2:0]  f3;
    logic        f7b5;
    logic [63:0] imm;
    logic [8:0]  fl;
  } bnd_t;

  bnd_t        q64[$];
  bnd_t        q32[$];
  int          vecs = 0;
  int          errs = 0;
  logic [63:0] pc_ctr = 64'h1000;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vecs++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic cmp(input string t, input bnd_t g, input bnd_t e);
    chk({t, "_pc"},    g.pc, e.pc);
    chk({t, "_fmt"},   64'(g.fmt), 64'(e.fmt));
    chk({t, "_rd"},    64'(g.rd), 64'(e.rd));
    chk({t, "_rs1"},   64'(g.rs1), 64'(e.rs1));
    chk({t, "_rs2"},   64'(g.rs2), 64'(e.rs2));
    chk({t, "_f3"},    64'(g.f3), 64'(e.f3));
    chk({t, "_f7b5"},  64'(g.f7b5), 64'(e.f7b5));
    chk({t, "_imm"},   g.imm, e.imm);
    chk({t, "_flags"}, 64'(g.fl), 64'(e.fl));
  endtask

  function automatic bnd_t mk(input logic [63:0] pc, input logic [31:0] inst,
                              input logic [2:0] fmt, input logic [63:0] imm,
                              input logic [8:0] fl);
    bnd_t b;
    b.pc = pc; b.fmt = fmt; b.imm = imm; b.fl = fl;
    b.rd = inst[11:7]; b.rs1 = inst[19:15]; b.rs2 = inst[24:20];
    b.f3 = inst[14:12]; b.f7b5 = inst[30];
    return b;
  endfunction

  function automatic bnd_t get64();
    bnd_t g;
    g.pc = b64.out_pc; g.fmt = b64.fmt; g.rd = b64.rd; g.rs1 = b64.rs1; g.rs2 = b64.rs2;
    g.f3 = b64.funct3; g.f7b5 = b64.funct7b5; g.imm = b64.imm;
    g.fl = {b64.reg_wr, b64.mem_rd, b64.mem_wr, b64.branch, b64.jump, b64.word_op,
            b64.illegal, b64.ebreak, b64.ecall};
    return g;
  endfunction

  function automatic bnd_t get32();
    bnd_t g;
    g.pc = {32'b0, b32.out_pc}; g.fmt = b32.fmt; g.rd = b32.rd; g.rs1 = b32.rs1;
    g.rs2 = b32.rs2; g.f3 = b32.funct3; g.f7b5 = b32.funct7b5; g.imm = {32'b0, b32.imm};
    g.fl = {b32.reg_wr, b32.mem_rd, b32.mem_wr, b32.branch, b32.jump, b32.word_op,
            b32.illegal, b32.ebreak, b32.ecall};
    return g;
  endfunction

  // Check each bundle on the cycle the EXU takes it.
  always @(negedge clk) begin
    if (rst_n && b64.out_valid && b64.out_ready) begin
      if (q64.size() == 0) chk("sb64_underflow", 64'(q64.size()), 64'd1);
      else cmp("d64", get64(), q64.pop_front());
    end
    if (rst_n && b32.out_valid && b32.out_ready) begin
      if (q32.size() == 0) chk("sb32_underflow", 64'(q32.size()), 64'd1);
      else cmp("d32", get32(), q32.pop_front());
    end
  end

  // Call this at posedge+1. It holds the input until the DUT accepts it, and pushes the
  // expected bundle when the handshake completes.
  task automatic send(input bit is32, input logic [31:0] inst, input logic [2:0] fmt,
                      input logic [63:0] imm, input logic [8:0] fl);
    bit          acc = 1'b0;
    int          n   = 0;
    logic [63:0] pc  = is32 ? {32'b0, pc_ctr[31:0]} : pc_ctr;
    pc_ctr += 64'd4;
    if (is32) begin b32.in_valid = 1'b1; b32.in_inst = inst; b32.in_pc = pc[31:0]; end
    else      begin b64.in_valid = 1'b1; b64.in_inst = inst; b64.in_pc = pc;       end
    while (!acc && n < 20) begin
      @(negedge clk);
      acc = (is32 ? b32.in_ready : b64.in_ready) && !flush;
      if (acc) begin
        if (is32) q32.push_back(mk(pc, inst, fmt, imm, fl));
        else      q64.push_back(mk(pc, inst, fmt, imm, fl));
      end
      @(posedge clk); #1;
      n++;
    end
    if (!acc) chk("send_timeout", 64'(acc), 64'd1);
  endtask

  task automatic idle();
    b64.in_valid = 1'b0;
    b32.in_valid = 1'b0;
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [63:0] a_pc;
    b64.in_valid = 0; b64.in_inst = 0; b64.in_pc = 0; b64.out_ready = 1;
    b32.in_valid = 0; b32.in_inst = 0; b32.in_pc = 0; b32.out_ready = 1;
    #1 rst_n = 1'b0;
    #1;
    chk("rst_out_valid", 64'(b64.out_valid), 64'd0);
    chk("rst_in_ready",  64'(b64.in_ready), 64'd1);
    chk("rst_imm",       b64.imm, 64'd0);
    chk("rst_pc",        b64.out_pc, 64'd0);
    @(negedge clk) rst_n = 1'b1;
    cyc(1);

    // Back-to-back stream with out_ready=1, one instruction per cycle.
    send(0, 32'hFFF00093, 3'd1, 64'hFFFFFFFFFFFFFFFF, RW);      // addi x1,x0,-1
    send(0, 32'h0020A423, 3'd2, 64'd8, MW);                     // sw x2,8(x1)
    send(0, 32'h800002B7, 3'd4, 64'hFFFFFFFF80000000, RW);      // lui x5,0x80000
    send(0, 32'h00100073, 3'd1, 64'd1, EB);                     // ebreak
    send(0, 32'h00000073, 3'd1, 64'd0, EC);                     // ecall
    send(0, 32'h00000000, 3'd0, 64'd0, IL);                     // all-zero word
    send(0, 32'h00000013, 3'd1, 64'd0, NF);                     // nop (rd=x0)
    send(0, 32'hFE208EE3, 3'd3, 64'hFFFFFFFFFFFFFFFC, BR);      // beq x1,x2,-4
    send(0, 32'h008000EF, 3'd5, 64'd8, JP | RW);                // jal x1,+8
    send(0, 32'h000090E7, 3'd1, 64'd0, IL);                     // jalr with funct3=001
    send(0, 32'hFF813183, 3'd1, 64'hFFFFFFFFFFFFFFF8, MR | RW); // ld x3,-8(x2)
    send(0, 32'h402081B3, 3'd0, 64'd0, RW);                     // sub x3,x1,x2
    send(0, 32'h402091B3, 3'd0, 64'd0, IL);                     // funct7=0100000 with sll
    send(0, 32'h002081BB, 3'd0, 64'd0, RW | WO);                // addw x3,x1,x2
    send(0, 32'h43F0D093, 3'd1, 64'h43F, RW);                   // srai x1,x1,63
    send(0, 32'h00200073, 3'd1, 64'd2, IL);                     // unknown SYSTEM encoding
    idle();
    cyc(3);

    // Backpressure: the held bundle must stay put and the next one must wait.
    b64.out_ready = 1'b0;
    a_pc = pc_ctr;
    send(0, 32'h0020A423, 3'd2, 64'd8, MW);
    b64.in_valid = 1'b1; b64.in_inst = 32'h800002B7; b64.in_pc = 64'hDEAD;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("bp_in_ready",  64'(b64.in_ready), 64'd0);
      chk("bp_out_valid", 64'(b64.out_valid), 64'd1);
      chk("bp_pc",        b64.out_pc, a_pc);
      chk("bp_imm",       b64.imm, 64'd8);
      chk("bp_mem_wr",    64'(b64.mem_wr), 64'd1);
      @(posedge clk); #1;
    end
    b64.out_ready = 1'b1;
    send(0, 32'h800002B7, 3'd4, 64'hFFFFFFFF80000000, RW);
    idle();
    cyc(3);

    // A flush with an input the stage would otherwise accept: the input is dropped.
    flush = 1'b1;
    b64.in_valid = 1'b1; b64.in_inst = 32'hFFF00093; b64.in_pc = 64'hBEEF;
    @(negedge clk);
    chk("fl_in_ready", 64'(b64.in_ready), 64'd1);
    @(posedge clk); #1;
    flush = 1'b0; idle();
    @(negedge clk);
    chk("fl_drop_valid", 64'(b64.out_valid), 64'd0);
    @(posedge clk); #1;

    // A flush also kills a bundle held under backpressure.
    b64.out_ready = 1'b0;
    send(0, 32'hFFF00093, 3'd1, 64'hFFFFFFFFFFFFFFFF, RW);
    idle();
    flush = 1'b1;
    cyc(1);
    flush = 1'b0;
    void'(q64.pop_back());
    @(negedge clk);
    chk("fl_kill_valid", 64'(b64.out_valid), 64'd0);
    @(posedge clk); #1;
    b64.out_ready = 1'b1;
    send(0, 32'h00000013, 3'd1, 64'd0, NF);
    idle();
    cyc(2);

    // Asynchronous reset while a bundle is held.
    b64.out_ready = 1'b0;
    send(0, 32'h800002B7, 3'd4, 64'hFFFFFFFF80000000, RW);
    idle();
    @(negedge clk);
    chk("ar_pre_valid", 64'(b64.out_valid), 64'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("ar_out_valid", 64'(b64.out_valid), 64'd0);
    chk("ar_in_ready",  64'(b64.in_ready), 64'd1);
    chk("ar_pc",        b64.out_pc, 64'd0);
    chk("ar_rd",        64'(b64.rd), 64'd0);
    q64.delete();
    @(negedge clk) rst_n = 1'b1;
    b64.out_ready = 1'b1;
    cyc(1);

    // XLEN=32 instance: RV64-only encodings become illegal, and immediates are 32 bits.
    send(1, 32'h0000003B, 3'd0, 64'd0, IL);                     // OP-32
    send(1, 32'hFF813183, 3'd1, 64'hFFFFFFF8, IL);              // ld
    send(1, 32'h0020B423, 3'd2, 64'd8, IL);                     // sd
    send(1, 32'h43F0D093, 3'd1, 64'h43F, IL);                   // srai shamt bit 5 set
    send(1, 32'h41F0D093, 3'd1, 64'h41F, RW);                   // srai x1,x1,31
    send(1, 32'hFFF00093, 3'd1, 64'hFFFFFFFF, RW);              // addi x1,x0,-1
    send(1, 32'h800002B7, 3'd4, 64'h80000000, RW);              // lui x5,0x80000
    idle();
    cyc(3);

    chk("q64_drained", 64'(q64.size()), 64'd0);
    chk("q32_drained", 64'(q32.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule

// File: doc/idu_pipe.md
Name: idu_pipe

Overview:
- Registered, parametrised RV32I/RV64I decode stage for the NPC pipeline. It sits between the IFU and the EXU.
- Accepts one instruction and its PC per valid/ready handshake and decodes the full base integer ISA, not only ADDI.
- Produces a registered control bundle: register indices, format-correct sign-extended immediate, class flags, and illegal/ebreak/ecall detection.
- Supports flush and backpressure, so it can be used in a multi-cycle or pipelined core.

Parameters:
- XLEN, 64, datapath width. Legal values are 32 and 64. At 32, word-op and 64-bit load/store encodings are illegal.
- PC_W, 64, width of the PC carried alongside the instruction.

Ports:
- clk  in  1  Rising-edge clock.
- rst_n  in  1  Asynchronous, active-low reset.
- flush  in  1  Kill the held instruction and drop any same-cycle input.
- in_valid  in  1  IFU presents an instruction.
- in_ready  out  1  Decode stage can accept this cycle.
- in_inst  in  32  Instruction word.
- in_pc  in  PC_W  PC of in_inst.
- out_valid  out  1  Decoded bundle valid.
- out_ready  in  1  EXU consumes the bundle.
- out_pc  out  PC_W  Registered PC.
- rs1, rs2, rd  out  5 each  Register indices: inst[19:15], inst[24:20], inst[11:7].
- imm  out  XLEN  Sign-extended immediate for the decoded format; 0 for R-type.
- fmt  out  3  Format code: R=0, I=1, S=2, B=3, U=4, J=5.
- funct3  out  3  inst[14:12].
- funct7b5  out  1  inst[30].
- reg_wr, mem_rd, mem_wr, branch, jump, word_op  out  1 each  Class flags.
- illegal, ebreak, ecall  out  1 each  Exception flags.

Behaviour:
Reset:
- Asynchronous on rst_n low. out_valid=0 and every registered output=0.
- in_ready is combinational and equals 1 during reset.

Handshake:
- in_ready = !out_valid || out_ready.
- Accept occurs when in_valid && in_ready && !flush. Outputs load on the next rising edge, giving 1-cycle latency.
- If out_valid && out_ready with no accept, out_valid clears next cycle.
- With out_valid=1 and out_ready=0, all outputs hold stable.
- A full-throughput stream with out_ready=1 gives 1 instruction per cycle.

Flush:
- Has priority over everything. out_valid=0 next cycle, and a same-cycle input is dropped even if in_valid=1.
- Data outputs are don't-care while out_valid=0.

Decode by opcode:
- Applies only when in_inst[1:0]==2'b11; otherwise illegal.
- 0110111 LUI / 0010111 AUIPC: fmt U, reg_wr.
- 1101111 JAL: fmt J, jump, reg_wr.
- 1100111 JALR: legal only with funct3=000. fmt I, jump, reg_wr.
- 1100011 BRANCH: fmt B, branch. funct3 010 and 011 are illegal.
- 0000011 LOAD: fmt I, mem_rd, reg_wr. funct3 111 is illegal. At XLEN=32, funct3 011 and 110 are also illegal.
- 0100011 STORE: fmt S, mem_wr. funct3 >011 is illegal, and 011 is illegal at XLEN=32.
- 0010011 OP-IMM: fmt I, reg_wr.
  - funct3 001 requires inst[31:26]==0.
  - funct3 101 requires inst[31:26] to be 000000 or 010000.
  - At XLEN=32, shamt bit 25 must be 0.
- 0110011 OP: fmt R, reg_wr. funct7 must be 0000000, or 0100000 with funct3 000/101.
- 0011011 OP-IMM-32 / 0111011 OP-32: word_op, reg_wr, same funct checks restricted to 32-bit forms. Illegal at XLEN=32.
- 1110011 SYSTEM: only 0x00000073 (ecall) and 0x00100073 (ebreak) are legal. fmt I, no reg_wr.
- 0001111 FENCE: legal, all flags 0.
- Any other opcode is illegal.

Immediates:
- Built per fmt (I/S/B/J with bit 0=0 for B/J, U = inst[31:12]<<12).
- Sign-extended from inst[31] to XLEN.

Flag overrides:
- illegal=1 forces reg_wr, mem_rd, mem_wr, branch, jump, ebreak and ecall to 0.
- rd==0 forces reg_wr=0.
- Flags are mutually consistent: at most one of mem_rd, mem_wr, branch, jump is set.

Test Plan:
- Reset mid-stream with out_valid=1: rst_n low -> out_valid=0 immediately (async) and in_ready=1.
- XLEN=64, 0xFFF00093 (addi x1,x0,-1) -> next cycle out_valid=1, fmt=1, rd=1, rs1=0, imm=0xFFFFFFFFFFFFFFFF, reg_wr=1, illegal=0.
- 0x0020A423 (sw x2,8(x1)) -> fmt=2, rs1=1, rs2=2, imm=8, mem_wr=1, reg_wr=0. Then 0x800002B7 (lui x5,0x80000) -> fmt=4, rd=5, imm=0xFFFFFFFF80000000.
- 0x00100073 -> ebreak=1, reg_wr=0. 0x00000000 -> illegal=1, all class flags 0. At XLEN=32, 0x0000003B -> illegal=1.
- Backpressure: out_ready=0 for 3 cycles with in_valid=1 -> in_ready=0 and outputs stable. Then out_ready=1 -> next instruction loaded the following cycle, no loss or duplication.
- flush=1 concurrent with an accepting in_valid -> out_valid=0 next cycle. 0x00000013 (addi x0,x0,0) -> reg_wr=0, illegal=0.
